// File: rtl/drone_rx_pkg.sv
// drone_rx_pkg: shared types and constants
// for the drone camera link receive deframer.
package drone_rx_pkg;

  typedef enum logic [2:0] {
    ST_HUNT_HI,
    ST_HUNT_LO,
    ST_HDR,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_PAYLOAD,
    ST_CHK
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CH   = 2'd1;
  localparam logic [1:0] ERR_LEN  = 2'd2;
  localparam logic [1:0] ERR_CHK  = 2'd3;

  localparam logic [15:0] DEF_SYNC = 16'hA55A;

  localparam int DEF_OUT_W      = 16;
  localparam int BYTES_PER_WORD = DEF_OUT_W / 8;

  function automatic int bytes_per_word(input int w);
    return w / 8;
  endfunction

endpackage

// File: rtl/drone_rx_word_packer.sv
// drone_rx_word_packer: packs payload bytes LSB-first
// into words and holds each word until it is taken.
module drone_rx_word_packer
  import drone_rx_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic [7:0]       byte_i,
  input  logic             byte_valid_i,
  input  logic             last_i,
  input  logic [3:0]       ch_i,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] out_data_o,
  output logic [3:0]       out_ch_o,
  output logic             out_last_o,
  output logic             out_valid_o
);

  localparam int BPW = bytes_per_word(OUT_W);
  localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(BPW - 1);

  logic [OUT_W-1:0] part_q, part_d, word;
  logic [IW-1:0]    idx_q, idx_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic [3:0]       ch_q, ch_d;
  logic             last_q, last_d;
  logic             valid_q, valid_d;

  // Insert the byte into its lane; a full word
  // moves into the holding register.
  always_comb begin
    part_d  = part_q;
    idx_d   = idx_q;
    data_d  = data_q;
    ch_d    = ch_q;
    last_d  = last_q;
    valid_d = valid_q;
    word    = part_q;
    word[8*int'(idx_q) +: 8] = byte_i;
    if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end
    if (clr_i) begin
      idx_d = '0;
    end
    if (byte_valid_i) begin
      part_d = word;
      if (idx_q == IDX_LAST) begin
        idx_d   = '0;
        data_d  = word;
        ch_d    = ch_i;
        last_d  = last_i;
        valid_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Packing and holding registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      part_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      ch_q    <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      part_q  <= part_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign out_data_o  = data_q;
  assign out_ch_o    = ch_q;
  assign out_last_o  = last_q;
  assign out_valid_o = valid_q;

endmodule

// File: rtl/drone_rx_deframer.sv
// drone_rx_deframer: sync hunt, header/length checks,
// XOR checksum and packet counters.
module drone_rx_deframer
  import drone_rx_pkg::*;
#(
  parameter logic [15:0] SYNC    = DEF_SYNC,
  parameter int          NUM_CH  = 4,
  parameter int          OUT_W   = 16,
  parameter int          MAX_LEN = 1024
) (
  input  logic             sys_clock,
  input  logic             sys_rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [3:0]       out_ch,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             pkt_ok,
  output logic             pkt_err,
  output logic [1:0]       err_code,
  output logic [15:0]      pkt_cnt,
  output logic [15:0]      err_cnt
);

  localparam int BPW = bytes_per_word(OUT_W);

  state_e      state_q, state_d;
  logic [3:0]  ch_q, ch_d;
  logic [7:0]  len_hi_q, len_hi_d;
  logic [15:0] rem_q, rem_d;
  logic [7:0]  xor_q, xor_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic [15:0] ecnt_q, ecnt_d;

  logic        acc;
  logic [15:0] len_w;
  logic        ch_bad, len_bad;
  logic        pk_v, pk_last, pk_clr;

  assign in_ready = !sys_rst && !(out_valid && !out_ready);
  assign acc      = in_valid && in_ready;
  assign len_w    = {len_hi_q, in_data};
  assign ch_bad   = 32'(in_data[3:0]) >= 32'(NUM_CH);
  assign len_bad  = (len_w == 16'd0)
                 || (32'(len_w) > 32'(MAX_LEN))
                 || ((32'(len_w) % 32'(BPW)) != 32'd0);

  // Next state, packet checks and status pulses.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    len_hi_d = len_hi_q;
    rem_d    = rem_q;
    xor_d    = xor_q;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    code_d   = code_q;
    pcnt_d   = pcnt_q;
    ecnt_d   = ecnt_q;
    pk_v     = 1'b0;
    pk_last  = 1'b0;
    pk_clr   = 1'b0;
    if (acc) begin
      unique case (state_q)
        ST_HUNT_HI: begin
          if (in_data == SYNC[15:8]) state_d = ST_HUNT_LO;
        end
        ST_HUNT_LO: begin
          if (in_data == SYNC[7:0]) begin
            state_d = ST_HDR;
            rem_d   = '0;
            xor_d   = '0;
            pk_clr  = 1'b1;
          end else if (in_data != SYNC[15:8]) begin
            state_d = ST_HUNT_HI;
          end
        end
        ST_HDR: begin
          if (ch_bad) begin
            err_d   = 1'b1;
            code_d  = ERR_CH;
            state_d = ST_HUNT_HI;
          end else begin
            ch_d    = in_data[3:0];
            xor_d   = in_data;
            state_d = ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          len_hi_d = in_data;
          xor_d    = xor_q ^ in_data;
          state_d  = ST_LEN_LO;
        end
        ST_LEN_LO: begin
          if (len_bad) begin
            err_d   = 1'b1;
            code_d  = ERR_LEN;
            state_d = ST_HUNT_HI;
          end else begin
            rem_d   = len_w;
            xor_d   = xor_q ^ in_data;
            state_d = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          pk_v    = 1'b1;
          pk_last = (rem_q == 16'd1);
          xor_d   = xor_q ^ in_data;
          rem_d   = rem_q - 16'd1;
          if (rem_q == 16'd1) state_d = ST_CHK;
        end
        ST_CHK: begin
          if (in_data == xor_q) begin
            ok_d   = 1'b1;
            code_d = ERR_NONE;
          end else begin
            err_d  = 1'b1;
            code_d = ERR_CHK;
          end
          state_d = ST_HUNT_HI;
        end
        default: state_d = ST_HUNT_HI;
      endcase
    end
    if (ok_d && pcnt_q != 16'hFFFF) pcnt_d = pcnt_q + 16'd1;
    if (err_d && ecnt_q != 16'hFFFF) ecnt_d = ecnt_q + 16'd1;
  end

  // State, checksum and counter registers.
  always_ff @(posedge sys_clock) begin
    if (sys_rst) begin
      state_q  <= ST_HUNT_HI;
      ch_q     <= '0;
      len_hi_q <= '0;
      rem_q    <= '0;
      xor_q    <= '0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= ERR_NONE;
      pcnt_q   <= '0;
      ecnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      len_hi_q <= len_hi_d;
      rem_q    <= rem_d;
      xor_q    <= xor_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      code_q   <= code_d;
      pcnt_q   <= pcnt_d;
      ecnt_q   <= ecnt_d;
    end
  end

  drone_rx_word_packer #(
    .OUT_W (OUT_W)
  ) u_packer (
    .clk_i        (sys_clock),
    .rst_i        (sys_rst),
    .clr_i        (pk_clr),
    .byte_i       (in_data),
    .byte_valid_i (pk_v),
    .last_i       (pk_last),
    .ch_i         (ch_q),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data),
    .out_ch_o     (out_ch),
    .out_last_o   (out_last),
    .out_valid_o  (out_valid)
  );

  assign pkt_ok   = ok_q;
  assign pkt_err  = err_q;
  assign err_code = code_q;
  assign pkt_cnt  = pcnt_q;
  assign err_cnt  = ecnt_q;

endmodule

// File: tb/tb_drone_rx_deframer.sv
// tb_drone_rx_deframer: directed and random packets
// checked against a stream-level packet parser.
module tb_drone_rx_deframer;

  logic        sys_clock = 1'b0;
  logic        sys_rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic [3:0]  out_ch;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic        pkt_ok;
  logic        pkt_err;
  logic [1:0]  err_code;
  logic [15:0] pkt_cnt;
  logic [15:0] err_cnt;

  drone_rx_deframer dut (
    .sys_clock (sys_clock),
    .sys_rst   (sys_rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pkt_ok    (pkt_ok),
    .pkt_err   (pkt_err),
    .err_code  (err_code),
    .pkt_cnt   (pkt_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 sys_clock = ~sys_clock;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  ch;
    logic        last;
  } word_t;

  int n_cmp = 0;
  int n_bad = 0;
  int m_ok  = 0;
  int m_err = 0;
  int rdy_mode = 0;
  bit ignore = 1'b0;

  word_t      exp_w[$];
  logic [1:0] exp_e[$];
  logic [7:0] stim[$];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Consumer readiness: always, random, or held off.
  always @(posedge sys_clock) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // Scoreboard: accepted words and status pulses.
  always @(negedge sys_clock) begin
    word_t w;
    logic [1:0] e;
    if (!ignore && !sys_rst) begin
      if (out_valid && out_ready) begin
        n_cmp++;
        assert (exp_w.size() > 0) else begin
          n_bad++;
          $error("FAIL unexpected_word: observed %0h expected none",
                 out_data);
        end
        if (exp_w.size() > 0) begin
          w = exp_w.pop_front();
          check("word", 32'({out_data, out_ch, out_last}),
                32'({w.d, w.ch, w.last}));
        end
      end
      if (pkt_ok || pkt_err) begin
        n_cmp++;
        assert (exp_e.size() > 0) else begin
          n_bad++;
          $error("FAIL unexpected_status: observed ok=%0b err=%0b expected none",
                 pkt_ok, pkt_err);
        end
        if (exp_e.size() > 0) begin
          e = exp_e.pop_front();
          check("status_flags", 32'({pkt_ok, pkt_err}),
                (e == 2'd0) ? 32'd2 : 32'd1);
          check("err_code", 32'(err_code), 32'(e));
        end
      end
    end
  end

  // Stream parser: find A5 5A, then apply the packet rules.
  task automatic model(input logic [7:0] s[$]);
    int i, n, len;
    logic [7:0] hdr, x;
    word_t w;
    i = 0;
    n = s.size();
    while (i + 1 < n) begin
      if (s[i] == 8'hA5 && s[i+1] == 8'h5A) begin
        i += 2;
        if (i >= n) break;
        hdr = s[i];
        i++;
        if (hdr[3:0] >= 4'd4) begin
          exp_e.push_back(2'd1);
          m_err++;
          continue;
        end
        if (i + 1 >= n) break;
        len = {s[i], s[i+1]};
        i += 2;
        if (len == 0 || len > 1024 || (len % 2) != 0) begin
          exp_e.push_back(2'd2);
          m_err++;
          continue;
        end
        if (i + len >= n) break;
        x = hdr ^ s[i-2] ^ s[i-1];
        for (int k = 0; k < len; k++) x ^= s[i+k];
        for (int k = 0; k < len / 2; k++) begin
          w.d    = {s[i+2*k+1], s[i+2*k]};
          w.ch   = hdr[3:0];
          w.last = (k == len / 2 - 1);
          exp_w.push_back(w);
        end
        if (s[i+len] == x) begin
          exp_e.push_back(2'd0);
          m_ok++;
        end else begin
          exp_e.push_back(2'd3);
          m_err++;
        end
        i += len + 1;
      end else begin
        i++;
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    bit ok;
    t = 0;
    in_data  = b;
    in_valid = 1'b1;
    forever begin
      @(negedge sys_clock);
      ok = in_ready;
      @(posedge sys_clock);
      #1;
      if (ok) break;
      t++;
      if (t > 500) begin
        n_cmp++;
        n_bad++;
        $error("FAIL send_timeout: observed stalled expected accept");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  function automatic logic [7:0] rnd_byte();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    while (b == 8'hA5) b = 8'($urandom_range(0, 255));
    return b;
  endfunction

  task automatic add_pkt(input logic [7:0] hdr, input int len,
                         input int npay, input bit good);
    logic [7:0] x, b;
    logic [15:0] l;
    l = 16'(len);
    x = hdr ^ l[15:8] ^ l[7:0];
    stim.push_back(8'hA5);
    stim.push_back(8'h5A);
    stim.push_back(hdr);
    stim.push_back(l[15:8]);
    stim.push_back(l[7:0]);
    for (int k = 0; k < npay; k++) begin
      b = rnd_byte();
      stim.push_back(b);
      x ^= b;
    end
    stim.push_back(good ? x : (x ^ 8'h01));
  endtask

  task automatic add_bytes(input logic [7:0] a[$]);
    foreach (a[k]) stim.push_back(a[k]);
  endtask

  task automatic run_stream();
    model(stim);
    foreach (stim[k]) send(stim[k]);
    stim.delete();
  endtask

  task automatic drain_check(input string tag);
    rdy_mode = 0;
    repeat (20) @(posedge sys_clock);
    @(negedge sys_clock);
    check({tag, "_words_left"}, 32'(exp_w.size()), 32'd0);
    check({tag, "_status_left"}, 32'(exp_e.size()), 32'd0);
    check({tag, "_pkt_cnt"}, 32'(pkt_cnt), 32'(m_ok));
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'(m_err));
  endtask

  initial begin
    logic [7:0] hdr, f;
    int kind, len, lens[4];
    sys_rst   = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;

    repeat (3) @(posedge sys_clock);
    @(negedge sys_clock);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_ch", 32'(out_ch), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_pulses", 32'({pkt_ok, pkt_err}), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge sys_clock);
    #1 sys_rst = 1'b0;

    // Good packet: words 0x2211, 0x4433 on channel 2.
    add_bytes('{8'hA5, 8'h5A, 8'h02, 8'h00, 8'h04,
                8'h11, 8'h22, 8'h33, 8'h44, 8'h42});
    run_stream();
    drain_check("good");

    // Sync slip with a repeated high byte.
    add_bytes('{8'h00, 8'hA5, 8'hA5, 8'h5A, 8'h01,
                8'h00, 8'h02, 8'hAA, 8'hBB, 8'h10});
    run_stream();
    drain_check("slip");

    // Bad channel, then a good packet.
    add_pkt(8'h07, 2, 2, 1'b1);
    add_pkt(8'h03, 4, 4, 1'b1);
    run_stream();
    drain_check("badch");

    // Odd length, then a bad checksum.
    add_pkt(8'h01, 3, 4, 1'b1);
    add_pkt(8'h00, 4, 4, 1'b0);
    run_stream();
    drain_check("badlen_chk");

    // Consumer stalls for five cycles mid-packet.
    add_pkt(8'h03, 8, 8, 1'b1);
    model(stim);
    for (int k = 0; k < 6; k++) send(stim[k]);
    rdy_mode = 2;
    @(posedge sys_clock);
    #2;
    fork
      begin
        for (int k = 6; k < stim.size(); k++) send(stim[k]);
      end
      begin
        @(negedge sys_clock);
        repeat (5) begin
          @(negedge sys_clock);
          check("bp_in_ready", 32'(in_ready), 32'd0);
          check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        rdy_mode = 0;
      end
    join
    stim.delete();
    drain_check("backpressure");

    // Random packets, fillers and consumer stalls.
    lens = '{0, 3, 1026, 7};
    rdy_mode = 1;
    for (int p = 0; p < 40; p++) begin
      for (int k = $urandom_range(0, 3); k > 0; k--) begin
        f = rnd_byte();
        while (f == 8'h5A) f = rnd_byte();
        stim.push_back(f);
      end
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        hdr = {4'($urandom_range(0, 7)), 4'($urandom_range(4, 15))};
        add_pkt(hdr, 2, 2, 1'b1);
      end else if (kind == 1) begin
        hdr = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 3))};
        add_pkt(hdr, lens[$urandom_range(0, 3)], 4, 1'b1);
      end else begin
        hdr = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 3))};
        len = 2 * $urandom_range(1, 8);
        add_pkt(hdr, len, len, $urandom_range(0, 4) != 0);
      end
    end
    run_stream();
    drain_check("random");

    // Reset in the middle of a payload with a word held.
    ignore = 1'b1;
    rdy_mode = 2;
    @(posedge sys_clock);
    #2;
    add_bytes('{8'hA5, 8'h5A, 8'h01, 8'h00, 8'h04, 8'h11, 8'h22});
    foreach (stim[k]) send(stim[k]);
    stim.delete();
    @(negedge sys_clock);
    sys_rst = 1'b1;
    @(posedge sys_clock);
    #1;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd0);
    @(posedge sys_clock);
    #1;
    check("rst_mid_pkt_cnt", 32'(pkt_cnt), 32'd0);
    check("rst_mid_err_cnt", 32'(err_cnt), 32'd0);
    rdy_mode = 0;
    m_ok = 0;
    m_err = 0;
    exp_w.delete();
    exp_e.delete();
    sys_rst = 1'b0;
    @(posedge sys_clock);
    #2;
    ignore = 1'b0;
    add_bytes('{8'hA5, 8'h5A, 8'h02, 8'h00, 8'h02,
                8'h77, 8'h66, 8'h13});
    run_stream();
    drain_check("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
